// File: rtl/pattern_field_packer.sv
// Packs fixed-width extracted fields LSB-first into WORD_W-bit words.
// Packets end with a zero-padded, out_last-flagged partial or full word.
module pattern_field_packer #(
  parameter logic [255:0] PATTERN = 256'("whatever"),
  parameter int WORD_W = 64,
  localparam int FIELD_W = $countones(PATTERN),
  localparam int BITS_W = $clog2(WORD_W + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FIELD_W-1:0] in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORD_W-1:0]  out_data,
  output logic [BITS_W-1:0]  out_bits,
  output logic               out_last
);

  localparam int ACC_W  = 2 * WORD_W;
  localparam int FILL_W = $clog2(ACC_W + 1);

  localparam logic [FILL_W-1:0] C_WORD  = FILL_W'(WORD_W);
  localparam logic [FILL_W-1:0] C_FIELD = FILL_W'(FIELD_W);
  localparam logic [FILL_W-1:0] C_RMAX  = FILL_W'(ACC_W - FIELD_W);

  if (FIELD_W < 1 || FIELD_W > WORD_W) begin : g_bad_cfg
    $error("pattern_field_packer: FIELD_W must be 1..WORD_W");
  end

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ACC_W-1:0]    r_acc;
  logic [ACC_W-1:0]    w_acc_nxt;
  logic [ACC_W-1:0]    w_shift;
  logic [FILL_W-1:0]   r_fill;
  logic [FILL_W-1:0]   w_fill_nxt;
  logic [FILL_W-1:0]   w_emit;
  logic [FILL_W-1:0]   w_rem;
  logic                w_accept;
  logic                w_load;
  logic                w_last_word;
  logic                r_out_valid;
  logic [WORD_W-1:0]   r_out_data;
  logic [BITS_W-1:0]   r_out_bits;
  logic                r_out_last;

  assign in_ready  = (r_state == RUN) && (r_fill <= C_RMAX);
  assign w_accept  = in_valid && in_ready;
  assign w_load    = (!r_out_valid || out_ready) &&
                     ((r_fill >= C_WORD) ||
                      ((r_state == FLUSH) && (r_fill != '0)));

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_bits  = r_out_bits;
  assign out_last  = r_out_last;

  // Next accumulator/fill after emitting a word and appending a field.
  always_comb begin
    w_state_nxt = r_state;
    w_emit      = '0;
    w_last_word = 1'b0;
    if (w_load) begin
      w_emit      = (r_fill >= C_WORD) ? C_WORD : r_fill;
      w_last_word = (r_state == FLUSH) && (r_fill == w_emit);
    end
    w_shift    = r_acc >> w_emit;
    w_rem      = r_fill - w_emit;
    w_acc_nxt  = w_shift;
    w_fill_nxt = w_rem;
    if (w_accept) begin
      w_acc_nxt  = w_shift | (ACC_W'(in_data) << w_rem);
      w_fill_nxt = w_rem + C_FIELD;
    end
    unique case (r_state)
      RUN:   if (w_accept && in_last) w_state_nxt = FLUSH;
      FLUSH: if (r_out_valid && out_ready && r_out_last) w_state_nxt = RUN;
    endcase
  end

  // State, accumulator and fill count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_acc   <= '0;
      r_fill  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_fill  <= w_fill_nxt;
    end
  end

  // Output word register; holds while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_bits  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= r_acc[WORD_W-1:0];
      r_out_bits  <= BITS_W'(w_emit);
      r_out_last  <= w_last_word;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pattern_field_packer.sv
// Directed bench for pattern_field_packer: default 33->64 config
// and a 1-bit-field, 8-bit-word config side by side.
module tb_pattern_field_packer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_in_last;
  logic [32:0] a_in_data;
  logic        a_out_valid, a_out_ready, a_out_last;
  logic [63:0] a_out_data;
  logic [6:0]  a_out_bits;

  logic        b_in_valid, b_in_ready, b_in_last;
  logic [0:0]  b_in_data;
  logic        b_out_valid, b_out_ready, b_out_last;
  logic [7:0]  b_out_data;
  logic [3:0]  b_out_bits;

  pattern_field_packer u_dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_last(a_in_last),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_bits(a_out_bits),
    .out_last(a_out_last)
  );

  pattern_field_packer #(
    .PATTERN(256'("@")),
    .WORD_W(8)
  ) u_dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_bits(b_out_bits),
    .out_last(b_out_last)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input bit sel, input logic [32:0] d, input logic l);
    int n;
    n = 0;
    if (sel) begin
      b_in_valid = 1'b1; b_in_data = d[0]; b_in_last = l;
    end else begin
      a_in_valid = 1'b1; a_in_data = d; a_in_last = l;
    end
    while (!(sel ? b_in_ready : a_in_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", 64'(sel ? b_in_ready : a_in_ready), 64'(1));
    @(negedge clk);
    a_in_valid = 1'b0; a_in_last = 1'b0;
    b_in_valid = 1'b0; b_in_last = 1'b0;
  endtask

  task automatic pop_chk(input bit sel, input string tag,
                         input logic [63:0] ed, input logic [6:0] eb,
                         input logic el);
    int n;
    logic v;
    n = 0;
    v = sel ? b_out_valid : a_out_valid;
    while (!v && n < 300) begin
      @(negedge clk);
      n++;
      v = sel ? b_out_valid : a_out_valid;
    end
    chk({tag, "_valid"}, 64'(v), 64'(1));
    if (sel) begin
      chk({tag, "_data"}, 64'(b_out_data), ed);
      chk({tag, "_bits"}, 64'(b_out_bits), 64'(eb));
      chk({tag, "_last"}, 64'(b_out_last), 64'(el));
      b_out_ready = 1'b1;
    end else begin
      chk({tag, "_data"}, a_out_data, ed);
      chk({tag, "_bits"}, 64'(a_out_bits), 64'(eb));
      chk({tag, "_last"}, 64'(a_out_last), 64'(el));
      a_out_ready = 1'b1;
    end
    @(negedge clk);
    a_out_ready = 1'b0;
    b_out_ready = 1'b0;
  endtask

  logic [32:0]  fa, fb, fc, fd;
  logic [32:0]  f [6];
  logic [197:0] s;
  logic [7:0]   pat;

  initial begin
    rst = 1'b1;
    a_in_valid = 0; a_in_data = '0; a_in_last = 0; a_out_ready = 0;
    b_in_valid = 0; b_in_data = '0; b_in_last = 0; b_out_ready = 0;
    fa = 33'h1_2345_6789;
    fb = 33'h0_9ABC_DEF1;
    fc = 33'h1_5555_AAAA;
    fd = 33'h0_0F0F_3C3C;

    // reset state, observed while rst is still high
    #1;
    chk("rst_in_ready", 64'(a_in_ready), 64'(1));
    chk("rst_out_valid", 64'(a_out_valid), 64'(0));
    chk("rst_out_data", a_out_data, 64'(0));
    chk("rst_out_bits", 64'(a_out_bits), 64'(0));
    chk("rst_out_last", 64'(a_out_last), 64'(0));
    chk("rst_b_in_ready", 64'(b_in_ready), 64'(1));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 64'(a_in_ready), 64'(1));

    // two fields, no last: one full word, 2 bits left over
    push(0, fa, 0);
    push(0, fb, 0);
    pop_chk(0, "ab_w0", 64'({fb[30:0], fa}), 7'd64, 1'b0);
    push(0, fc, 1);
    pop_chk(0, "ab_tail", 64'({fc, fb[32:31]}), 7'd35, 1'b1);
    chk("ab_ready_after", 64'(a_in_ready), 64'(1));
    chk("ab_no_extra", 64'(a_out_valid), 64'(0));

    // single field with last
    push(0, fa, 1);
    chk("single_ready_lo", 64'(a_in_ready), 64'(0));
    repeat (3) @(negedge clk);
    chk("single_hold_data", a_out_data, 64'({31'b0, fa}));
    chk("single_ready_lo2", 64'(a_in_ready), 64'(0));
    pop_chk(0, "single", 64'({31'b0, fa}), 7'd33, 1'b1);
    chk("single_ready_hi", 64'(a_in_ready), 64'(1));
    chk("single_no_extra", 64'(a_out_valid), 64'(0));

    // back-pressure: out_ready low while fields pile up
    for (int i = 0; i < 6; i++)
      f[i] = 33'({i[3:0], 4'h5, i[3:0], 4'hA, i[3:0], 4'hC, i[3:0],
                  4'h3, 1'b1});
    s = {f[5], f[4], f[3], f[2], f[1], f[0]};
    for (int i = 0; i < 4; i++) push(0, f[i], 0);
    chk("bp_ready_at68", 64'(a_in_ready), 64'(1));
    push(0, f[4], 0);
    chk("bp_ready_at101", 64'(a_in_ready), 64'(0));
    chk("bp_hold0", a_out_data, s[63:0]);
    repeat (3) @(negedge clk);
    chk("bp_hold_valid", 64'(a_out_valid), 64'(1));
    chk("bp_hold1", a_out_data, s[63:0]);
    chk("bp_ready_still_lo", 64'(a_in_ready), 64'(0));
    pop_chk(0, "bp_w0", s[63:0], 7'd64, 1'b0);
    push(0, f[5], 1);
    pop_chk(0, "bp_w1", s[127:64], 7'd64, 1'b0);
    pop_chk(0, "bp_w2", s[191:128], 7'd64, 1'b0);
    pop_chk(0, "bp_w3", 64'(s[197:192]), 7'd6, 1'b1);
    chk("bp_ready_end", 64'(a_in_ready), 64'(1));

    // 1-bit fields, 9 bits total
    pat = 8'b0100_1101;
    for (int i = 0; i < 8; i++) push(1, 33'(pat[i]), 0);
    push(1, 33'(1), 1);
    pop_chk(1, "bit9_w0", 64'(8'h4D), 7'd8, 1'b0);
    pop_chk(1, "bit9_w1", 64'(8'h01), 7'd1, 1'b1);
    chk("bit9_ready", 64'(b_in_ready), 64'(1));

    // exactly one word: last flag on the full word, no empty word
    pat = 8'hA5;
    for (int i = 0; i < 8; i++) push(1, 33'(pat[i]), (i == 7));
    pop_chk(1, "bit8", 64'(8'hA5), 7'd8, 1'b1);
    repeat (4) @(negedge clk);
    chk("bit8_no_extra", 64'(b_out_valid), 64'(0));
    chk("bit8_ready", 64'(b_in_ready), 64'(1));

    // reset in the middle of a flush
    push(0, fa, 0);
    push(0, fb, 0);
    push(0, fc, 1);
    chk("mid_valid", 64'(a_out_valid), 64'(1));
    chk("mid_ready_lo", 64'(a_in_ready), 64'(0));
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(a_out_valid), 64'(0));
    chk("mid_rst_data", a_out_data, 64'(0));
    chk("mid_rst_last", 64'(a_out_last), 64'(0));
    chk("mid_rst_ready", 64'(a_in_ready), 64'(1));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_post_ready", 64'(a_in_ready), 64'(1));
    chk("mid_post_valid", 64'(a_out_valid), 64'(0));
    push(0, fd, 1);
    pop_chk(0, "mid_fresh", 64'({31'b0, fd}), 7'd33, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
